// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side signals of the hazard controller; HAZARD_PERF_EN adds the perf counters
interface pipeline_hazard_ctrl_if;
  logic [4:0] addr_rs_d, addr_rt_d, addr_rs_e, addr_rt_e, addr_wr_e, addr_wr_m, addr_wr_w;
  logic con_branch_d, con_ifbranch_d, con_jump_d, con_mduse_d;
  logic con_regwrite_e, con_memread_e, con_mdstart_e;
  logic con_regwrite_m, con_memread_m, con_regwrite_w;
  logic stall_f, stall_d, flush_d, flush_e, fwd_rs_d, fwd_rt_d, mdu_busy;
  logic [1:0] fwd_rs_e, fwd_rt_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  modport master (
    output addr_rs_d, addr_rt_d, addr_rs_e, addr_rt_e, addr_wr_e, addr_wr_m, addr_wr_w,
    output con_branch_d, con_ifbranch_d, con_jump_d, con_mduse_d,
    output con_regwrite_e, con_memread_e, con_mdstart_e,
    output con_regwrite_m, con_memread_m, con_regwrite_w,
    input stall_f, stall_d, flush_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, mdu_busy
`ifdef HAZARD_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input addr_rs_d, addr_rt_d, addr_rs_e, addr_rt_e, addr_wr_e, addr_wr_m, addr_wr_w,
    input con_branch_d, con_ifbranch_d, con_jump_d, con_mduse_d,
    input con_regwrite_e, con_memread_e, con_mdstart_e,
    input con_regwrite_m, con_memread_m, con_regwrite_w,
    output stall_f, stall_d, flush_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, mdu_busy
`ifdef HAZARD_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage MIPS pipeline plus mult/div busy tracking
// HAZARD_PERF_EN adds registered stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int MDU_CYCLES = 4
) (
  input logic i_clk,
  input logic i_nrst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [5:0] cnt_load = 6'(MDU_CYCLES - 1);
  state_t state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic lw_stall, br_stall, md_stall, stall, flush;
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return a != 5'd0 && a == b;
  endfunction
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic rw_m, input logic [4:0] wr_m,
                                         input logic rw_w, input logic [4:0] wr_w);
    return (rw_m && hit(wr_m, r)) ? 2'b10 : (rw_w && hit(wr_w, r)) ? 2'b01 : 2'b00;
  endfunction
  assign lw_stall = hz.con_memread_e && (hit(hz.addr_wr_e, hz.addr_rs_d) || hit(hz.addr_wr_e, hz.addr_rt_d));
  assign br_stall = hz.con_branch_d &&
                    ((hz.con_regwrite_e && (hit(hz.addr_wr_e, hz.addr_rs_d) || hit(hz.addr_wr_e, hz.addr_rt_d))) ||
                     (hz.con_memread_m && (hit(hz.addr_wr_m, hz.addr_rs_d) || hit(hz.addr_wr_m, hz.addr_rt_d))));
  assign md_stall = hz.con_mduse_d && (state == BUSY || hz.con_mdstart_e);
  // Every combinational output is gated so the async reset clears it immediately.
  assign stall = i_nrst && (lw_stall || br_stall || md_stall);
  assign flush = i_nrst && (hz.con_ifbranch_d || hz.con_jump_d) && !stall;
  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_e = stall;
  assign hz.flush_d = flush;
  assign hz.fwd_rs_d = i_nrst && hz.con_regwrite_m && !hz.con_memread_m && hit(hz.addr_wr_m, hz.addr_rs_d);
  assign hz.fwd_rt_d = i_nrst && hz.con_regwrite_m && !hz.con_memread_m && hit(hz.addr_wr_m, hz.addr_rt_d);
  assign hz.fwd_rs_e = i_nrst ? fwd_sel(hz.addr_rs_e, hz.con_regwrite_m, hz.addr_wr_m, hz.con_regwrite_w, hz.addr_wr_w) : 2'b00;
  assign hz.fwd_rt_e = i_nrst ? fwd_sel(hz.addr_rt_e, hz.con_regwrite_m, hz.addr_wr_m, hz.con_regwrite_w, hz.addr_wr_w) : 2'b00;
  assign hz.mdu_busy = state == BUSY;
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      state <= IDLE;
      cnt <= 6'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // A start while busy reloads the count rather than being ignored.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (hz.con_mdstart_e) begin
      state_nx = BUSY;
      cnt_nx = cnt_load;
    end else if (state == BUSY) begin
      state_nx = cnt == 6'd0 ? IDLE : BUSY;
      cnt_nx = cnt == 6'd0 ? 6'd0 : cnt - 6'd1;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      flush_cnt <= flush_cnt + 32'(flush);
    end
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plan steps plus random traffic against a rule-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int MDU = 4;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int unsigned cmp = 0;
  int unsigned fails = 0;
  int rem = 0;
  logic [31:0] sc = 0;
  logic [31:0] fc = 0;
  logic e_stall, e_flush;
  pipeline_hazard_ctrl_if hif();
  pipeline_hazard_ctrl #(.MDU_CYCLES(MDU)) dut (.i_clk(clk), .i_nrst(nrst), .hz(hif.slave));
  always #5 clk = ~clk;
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return a != 5'd0 && a == b;
  endfunction
  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (hif.con_regwrite_m && hit(hif.addr_wr_m, r)) return 2'b10;
    if (hif.con_regwrite_w && hit(hif.addr_wr_w, r)) return 2'b01;
    return 2'b00;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    {hif.addr_rs_d, hif.addr_rt_d, hif.addr_rs_e, hif.addr_rt_e, hif.addr_wr_e, hif.addr_wr_m, hif.addr_wr_w} = '0;
    {hif.con_branch_d, hif.con_ifbranch_d, hif.con_jump_d, hif.con_mduse_d} = '0;
    {hif.con_regwrite_e, hif.con_memread_e, hif.con_mdstart_e} = '0;
    {hif.con_regwrite_m, hif.con_memread_m, hif.con_regwrite_w} = '0;
  endtask
  task automatic check_all(input string tag);
    logic lw, br, md, st, fl, frs, frt;
    if (!nrst) begin
      rem = 0;
      sc = 0;
      fc = 0;
    end
    lw = hif.con_memread_e && (hit(hif.addr_wr_e, hif.addr_rs_d) || hit(hif.addr_wr_e, hif.addr_rt_d));
    br = hif.con_branch_d &&
         ((hif.con_regwrite_e && (hit(hif.addr_wr_e, hif.addr_rs_d) || hit(hif.addr_wr_e, hif.addr_rt_d))) ||
          (hif.con_memread_m && (hit(hif.addr_wr_m, hif.addr_rs_d) || hit(hif.addr_wr_m, hif.addr_rt_d))));
    md = hif.con_mduse_d && (rem > 0 || hif.con_mdstart_e);
    st = nrst && (lw || br || md);
    fl = nrst && (hif.con_ifbranch_d || hif.con_jump_d) && !st;
    frs = nrst && hif.con_regwrite_m && !hif.con_memread_m && hit(hif.addr_wr_m, hif.addr_rs_d);
    frt = nrst && hif.con_regwrite_m && !hif.con_memread_m && hit(hif.addr_wr_m, hif.addr_rt_d);
    chk({tag, ".stall_f"}, 32'(hif.stall_f), 32'(st));
    chk({tag, ".stall_d"}, 32'(hif.stall_d), 32'(st));
    chk({tag, ".flush_e"}, 32'(hif.flush_e), 32'(st));
    chk({tag, ".flush_d"}, 32'(hif.flush_d), 32'(fl));
    chk({tag, ".fwd_rs_d"}, 32'(hif.fwd_rs_d), 32'(frs));
    chk({tag, ".fwd_rt_d"}, 32'(hif.fwd_rt_d), 32'(frt));
    chk({tag, ".fwd_rs_e"}, 32'(hif.fwd_rs_e), nrst ? 32'(fwd_e(hif.addr_rs_e)) : 32'd0);
    chk({tag, ".fwd_rt_e"}, 32'(hif.fwd_rt_e), nrst ? 32'(fwd_e(hif.addr_rt_e)) : 32'd0);
    chk({tag, ".mdu_busy"}, 32'(hif.mdu_busy), 32'(nrst && rem > 0));
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, hif.stall_cnt, sc);
    chk({tag, ".flush_cnt"}, hif.flush_cnt, fc);
`endif
    e_stall = st;
    e_flush = fl;
  endtask
  task automatic tick(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    if (nrst) begin
      sc = sc + 32'(e_stall);
      fc = fc + 32'(e_flush);
      rem = hif.con_mdstart_e ? MDU : (rem > 0 ? rem - 1 : 0);
    end
    @(negedge clk);
  endtask
  initial begin
    clear();
    hif.con_memread_e = 1'b1;
    hif.addr_wr_e = 5'd2;
    hif.addr_rs_d = 5'd2;
    hif.con_regwrite_m = 1'b1;
    hif.addr_wr_m = 5'd2;
    hif.addr_rs_e = 5'd2;
    #2 check_all("reset");
    chk("reset.literal_stall", 32'(hif.stall_f), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    clear();
    hif.con_memread_e = 1'b1;
    hif.addr_wr_e = 5'd2;
    hif.addr_rs_d = 5'd2;
    #1 chk("lw.literal_stall", 32'(hif.stall_f), 32'd1);
    tick("lwstall");
    clear();
    hif.con_regwrite_w = 1'b1;
    hif.addr_wr_w = 5'd2;
    hif.addr_rs_e = 5'd2;
    #1 chk("lw.literal_fwd_w", 32'(hif.fwd_rs_e), 32'd1);
    tick("lw_fwd_w");
    clear();
    hif.con_regwrite_m = 1'b1;
    hif.addr_wr_m = 5'd5;
    hif.con_regwrite_w = 1'b1;
    hif.addr_wr_w = 5'd5;
    hif.addr_rs_e = 5'd5;
    hif.addr_rt_e = 5'd5;
    #1 chk("mprio.literal", 32'(hif.fwd_rs_e), 32'd2);
    tick("m_priority");
    hif.addr_rs_e = 5'd0;
    hif.addr_rt_e = 5'd0;
    hif.addr_wr_m = 5'd0;
    hif.addr_wr_w = 5'd0;
    tick("zero_reg");
    clear();
    hif.con_branch_d = 1'b1;
    hif.addr_rs_d = 5'd7;
    hif.con_regwrite_e = 1'b1;
    hif.addr_wr_e = 5'd7;
    tick("brstall_e");
    clear();
    hif.con_branch_d = 1'b1;
    hif.addr_rs_d = 5'd7;
    hif.con_regwrite_m = 1'b1;
    hif.addr_wr_m = 5'd7;
    hif.con_ifbranch_d = 1'b1;
    #1 chk("br.literal_flush", 32'(hif.flush_d), 32'd1);
    tick("br_fwd_taken");
    hif.con_memread_m = 1'b1;
    tick("brstall_m_load");
    clear();
    hif.con_mdstart_e = 1'b1;
    hif.con_mduse_d = 1'b1;
    tick("mdu_c0");
    hif.con_mdstart_e = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("mdu.literal_release", 32'(hif.mdu_busy), 32'd0);
      tick($sformatf("mdu_c%0d", i));
    end
    clear();
    hif.con_jump_d = 1'b1;
    hif.con_memread_e = 1'b1;
    hif.addr_wr_e = 5'd3;
    hif.addr_rt_d = 5'd3;
    tick("jump_lwstall");
    hif.con_memread_e = 1'b0;
    tick("jump_free");
    clear();
    hif.con_mdstart_e = 1'b1;
    tick("rst_mid_start");
    hif.con_mdstart_e = 1'b0;
    tick("rst_mid_busy");
    hif.con_mduse_d = 1'b1;
    #2 nrst = 1'b0;
    tick("rst_mid_assert");
    nrst = 1'b1;
    tick("rst_mid_release");
    for (int i = 0; i < 600; i++) begin
      nrst = $urandom_range(0, 63) != 0;
      hif.addr_rs_d = 5'($urandom_range(0, 3));
      hif.addr_rt_d = 5'($urandom_range(0, 3));
      hif.addr_rs_e = 5'($urandom_range(0, 3));
      hif.addr_rt_e = 5'($urandom_range(0, 3));
      hif.addr_wr_e = 5'($urandom_range(0, 3));
      hif.addr_wr_m = 5'($urandom_range(0, 3));
      hif.addr_wr_w = 5'($urandom_range(0, 3));
      {hif.con_branch_d, hif.con_ifbranch_d, hif.con_jump_d, hif.con_mduse_d} = 4'($urandom);
      {hif.con_regwrite_e, hif.con_memread_e} = 2'($urandom);
      {hif.con_regwrite_m, hif.con_memread_m, hif.con_regwrite_w} = 3'($urandom);
      hif.con_mdstart_e = $urandom_range(0, 7) == 0;
      tick("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Watches register addresses and control bits in the D, E, M and W stages.
- Generates fetch/decode stall, decode/execute flush, and forwarding selects for the decode comparator and the E-stage ALU.
- Owns a small FSM that tracks the multi-cycle mult/div unit and holds decode off while that unit is busy.

Parameters:
MDU_CYCLES, 4, cycles the mult/div unit is busy after a start (legal range 2..63)

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset; asynchronous, active-low
i_addr_rs_D  in  5  rs of instruction in decode
i_addr_rt_D  in  5  rt of instruction in decode
i_con_branch_D  in  1  decode holds beq/bne/bgez/bltz/jr (needs rs/rt compare)
i_con_ifbranch_D  in  1  branch taken, from decode comparator
i_con_jump_D  in  1  jump in decode (j/jal/jr)
i_con_mduse_D  in  1  decode holds mult/div/mfhi/mflo/mthi/mtlo
i_addr_rs_E  in  5  rs in execute
i_addr_rt_E  in  5  rt in execute
i_addr_wr_E  in  5  destination after regdst mux, execute
i_con_regwrite_E  in  1  execute writes register
i_con_memread_E  in  1  execute is a load
i_con_mdstart_E  in  1  execute starts mult/div
i_addr_wr_M  in  5  destination, memory stage
i_con_regwrite_M  in  1  memory stage writes register
i_con_memread_M  in  1  memory stage is a load
i_addr_wr_W  in  5  destination, writeback
i_con_regwrite_W  in  1  writeback writes register
o_stall_F  out  1  hold PC
o_stall_D  out  1  hold F/D pipe register
o_flush_D  out  1  clear F/D pipe register
o_flush_E  out  1  clear D/E pipe register (bubble)
o_fwd_rs_D  out  1  1 = compare rs from M-stage ALU result
o_fwd_rt_D  out  1  1 = compare rt from M-stage ALU result
o_fwd_rs_E  out  2  00 regfile, 01 W result, 10 M result
o_fwd_rt_E  out  2  same encoding as o_fwd_rs_E
o_mdu_busy  out  1  mult/div FSM in BUSY

Behaviour:
- Register $0 never matches any hazard or forward term.
- Forward E:
  - fwd_rs_E = 10 if regwrite_M and wr_M==rs_E;
  - else 01 if regwrite_W and wr_W==rs_E;
  - else 00.
  - M has priority over W. rt is handled identically.
- Forward D: fwd_rs_D = regwrite_M and not memread_M and wr_M==rs_D; same for rt.
  - Regbank is write-before-read, so there is no W-to-D path here.
- lwstall: memread_E and wr_E in {rs_D, rt_D}.
- brstall: branch_D and one of:
  - regwrite_E and wr_E in {rs_D, rt_D};
  - memread_M and wr_M in {rs_D, rt_D}.
- mdstall: mduse_D and (state==BUSY or mdstart_E).
- stall = lwstall | brstall | mdstall.
- Stall/flush outputs:
  - o_stall_F = o_stall_D = stall.
  - o_flush_E = stall.
  - o_flush_D = (ifbranch_D | jump_D) and not stall. A stall always beats the flush.
- MDU FSM, registered:
  - IDLE: on mdstart_E, go to BUSY with cnt = MDU_CYCLES-1.
  - BUSY: cnt decrements each cycle; when cnt==0, go to IDLE the next cycle. Busy lasts exactly MDU_CYCLES cycles.
  - mdstart_E while BUSY cannot occur (blocked by mdstall). If it does occur, it reloads cnt.
  - o_mdu_busy = (state==BUSY), registered.
- Reset, async while i_nrst low:
  - FSM goes to IDLE and cnt to 0.
  - o_mdu_busy is 0.
  - All stall, flush and forward outputs are forced to 0.
  - Reset asserted mid-BUSY abandons the operation.
- Outputs other than o_mdu_busy are combinational from inputs and state, with zero latency.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds o_stall_cnt (out, 32), a registered count of cycles with stall==1.
  - Adds o_flush_cnt (out, 32), a registered count of cycles with o_flush_D==1.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- lw $2 in E (wr_E=2, memread_E=1), D uses rs_D=2 -> stall_F=stall_D=flush_E=1 for one cycle; next cycle fwd_rs_E=01 once the load reaches W.
- add to $5 in M (regwrite_M=1, wr_M=5), W also writes $5, rs_E=5 -> fwd_rs_E=10 (M priority). Repeat with rs_E=0 and wr_M=0 -> fwd_rs_E=00.
- beq in D with rs_D=7 while E writes $7 -> one-cycle stall. Next cycle with $7 in M (ALU op) -> fwd_rs_D=1 and no stall. With ifbranch_D=1 -> flush_D=1.
- MDU_CYCLES=4: mdstart_E at cycle 0, mfhi in D from cycle 0 -> o_mdu_busy=1 for cycles 1-4, stall=1 for cycles 0-4, released at cycle 5.
- Jump in D simultaneously with lwstall -> flush_D=0 and stall=1. Next cycle, with no hazard -> flush_D=1.
- i_nrst low during BUSY with cnt=2 -> all outputs 0 immediately; after release, mduse_D=1 -> no stall.
